coin_sprite_scheduler: RTL and testbench
========================================

// Module: coin_sprite_scheduler
// PURPOSE
//  Shares the single coin sprite ROM/palette pipeline among NUM_COINS on-screen coins.
//  Per pixel: picks the covering coin and emits the ROM address (animation frame, row, col) plus in_sprite.
//  Also runs a per-coin lifecycle FSM (off / spin / pop-after-collect).
//  Sits between the game logic (coin config and collect events) and the coin sprite renderer.
// PARAMETERS
//  NUM_COINS   8    coins managed; index width CW=$clog2(NUM_COINS)
//  SPR_W       16   sprite width/height in pixels (square frame)
//  NUM_FRAMES  4    animation frames stacked vertically in ROM
//  ANIM_DIV    8    video frames per animation step
//  POP_FRAMES  16   video frames a collected coin stays visible rising before turning off
// PORTS
//  pixel_clk_in      in   1     pixel clock
//  rst_n_in          in   1     reset, asynchronous, active-low
//  hcount_in         in   11    current pixel x
//  vcount_in         in   10    current pixel y
//  cfg_valid_in      in   1     write coin config this cycle
//  cfg_idx_in        in   CW    coin index for cfg/enable
//  cfg_x_in          in   11    coin top-left x
//  cfg_y_in          in   10    coin top-left y
//  cfg_en_in         in   1     1: coin -> SPIN, 0: coin -> OFF
//  collect_valid_in  in   1     collect event
//  collect_idx_in    in   CW    coin collected
//  image_addr_out    out  10    ROM address = frame*SPR_W*SPR_W + row*SPR_W + col
//  in_sprite_out     out  1     pixel lies in a visible coin
//  hit_idx_out       out  CW    index of the coin drawn at this pixel
//  active_count_out  out  CW+1  coins in SPIN or POP
//  collected_pulse_out out 1    one-cycle pulse when a collect is accepted
// BEHAVIOUR
//  Reset (async assert, sync release): all coins OFF, positions 0, anim_ctr=0, div_ctr=0.
//   All outputs are 0.
//  frame_tick: one-cycle pulse, registered, on the cycle when hcount_in==0 && vcount_in==0.
//   div_ctr counts ticks 0..ANIM_DIV-1.
//   On wrap, anim_ctr increments mod NUM_FRAMES.
//  Config: writes go to shadow x/y/en regs.
//   Shadow is copied to active regs only on frame_tick, so there is no tearing mid-frame.
//   Last write before the tick wins.
//  Per-coin FSM, evaluated only on frame_tick:
//   OFF  -> SPIN when the shadow en is 1.
//   SPIN -> POP when collect is pending, load pop_ctr=POP_FRAMES-1, and y_off=0.
//   SPIN -> OFF when the shadow en is 0.
//   POP  -> each tick: pop_ctr--, y_off++ (coin drawn y_off pixels higher, clamped at y=0).
//   POP  -> OFF when pop_ctr==0 at a tick; the shadow en is also cleared.
//  Collect: accepted only if the coin is in SPIN and has no collect pending.
//   On accept: set pending, pulse collected_pulse_out the next cycle.
//   Otherwise ignored with no pulse.
//   Same-cycle cfg write with en=0 and collect to the same idx: the collect is still accepted.
//   The disable wins at the tick, so the coin goes straight to OFF.
//  Hit test per coin i (visible = SPIN|POP):
//   hcount in [x, x+SPR_W) and vcount in [y-y_off, y-y_off+SPR_W).
//   Use widened unsigned compare; no wrap at screen edges.
//  Overlap: the lowest index wins.
//  frame_sel = (anim_ctr + i) mod NUM_FRAMES for SPIN; fixed frame 0 for POP.
//  Outputs are registered.
//   Latency is 1 cycle from hcount/vcount to image_addr/in_sprite/hit_idx.
//   When no coin hits: in_sprite=0, image_addr=0, hit_idx=0.
//  active_count_out is updated the cycle after each frame_tick.
//  Reset asserted mid-frame: everything clears immediately; pending collects are lost.
// TESTING
//  Config coin 2 at (100,50), en=1, before a tick; pixel (103,55) after the tick
//   -> in_sprite=1, hit_idx=2, addr=(anim+2)%4*256+5*16+3, 1 cycle later.
//  Coin en written mid-frame -> no in_sprite until after the next (0,0) tick; then active_count=1.
//  Run 8 frames with ANIM_DIV=8 -> anim_ctr steps 0->1; after 32 frames it wraps 3->0.
//  Coins 1 and 4 overlapping at (200,200) -> hit_idx=1; after coin 1 goes OFF -> hit_idx=4.
//  Collect coin 3 in SPIN -> collected_pulse 1 cycle later; second collect ignored;
//   drawn 1..15 px higher over 16 ticks, frame 0; then OFF, active_count decrements.
//  Collect an OFF coin -> no pulse, no state change.
//  Drop rst_n_in mid-line -> outputs 0 asynchronously; all coins OFF after release.

Source files
------------

// File: rtl/coin_sprite_scheduler.sv
// coin_sprite_scheduler
//   Shares one coin sprite ROM among NUM_COINS on-screen coins. Each pixel
//   clock it finds the lowest-index visible coin covering (hcount, vcount)
//   and emits the registered ROM address (frame, row, col), in_sprite and the
//   coin index. Each coin also runs an OFF / SPIN / POP lifecycle, stepped
//   once per video frame.
// Ports
//   pixel_clk_in, rst_n_in     : clock, async active-low reset
//   hcount_in, vcount_in       : current pixel position
//   cfg_*                      : shadow position/enable write for one coin
//   collect_valid_in/idx_in    : collect event from game logic
//   image_addr_out             : frame*SPR_W*SPR_W + row*SPR_W + col
//   in_sprite_out, hit_idx_out : coverage result (1-cycle latency)
//   active_count_out           : coins in SPIN or POP
//   collected_pulse_out        : one-cycle pulse per accepted collect
module coin_sprite_scheduler #(
  parameter int NUM_COINS  = 8,
  parameter int SPR_W      = 16,
  parameter int NUM_FRAMES = 4,
  parameter int ANIM_DIV   = 8,
  parameter int POP_FRAMES = 16,
  localparam int CW        = $clog2(NUM_COINS)
) (
  input  logic          pixel_clk_in,
  input  logic          rst_n_in,
  input  logic [10:0]   hcount_in,
  input  logic [9:0]    vcount_in,
  input  logic          cfg_valid_in,
  input  logic [CW-1:0] cfg_idx_in,
  input  logic [10:0]   cfg_x_in,
  input  logic [9:0]    cfg_y_in,
  input  logic          cfg_en_in,
  input  logic          collect_valid_in,
  input  logic [CW-1:0] collect_idx_in,
  output logic [9:0]    image_addr_out,
  output logic          in_sprite_out,
  output logic [CW-1:0] hit_idx_out,
  output logic [CW:0]   active_count_out,
  output logic          collected_pulse_out
);

  localparam int DW = (ANIM_DIV   > 1) ? $clog2(ANIM_DIV)   : 1;
  localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int PW = (POP_FRAMES > 1) ? $clog2(POP_FRAMES) : 1;

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_SPIN = 2'd1,
    S_POP  = 2'd2
  } coin_state_t;

  logic          tick_q, tick_d;
  logic [DW-1:0] div_q, div_d;
  logic [FW-1:0] anim_q, anim_d;

  logic [10:0]   sh_x_q  [NUM_COINS];
  logic [10:0]   sh_x_d  [NUM_COINS];
  logic [9:0]    sh_y_q  [NUM_COINS];
  logic [9:0]    sh_y_d  [NUM_COINS];
  logic          sh_en_q [NUM_COINS];
  logic          sh_en_d [NUM_COINS];

  logic [10:0]   x_q     [NUM_COINS];
  logic [10:0]   x_d     [NUM_COINS];
  logic [9:0]    y_q     [NUM_COINS];
  logic [9:0]    y_d     [NUM_COINS];
  coin_state_t   state_q [NUM_COINS];
  coin_state_t   state_d [NUM_COINS];
  logic          pend_q  [NUM_COINS];
  logic          pend_d  [NUM_COINS];
  logic [PW-1:0] pop_q   [NUM_COINS];
  logic [PW-1:0] pop_d   [NUM_COINS];
  logic [PW-1:0] yoff_q  [NUM_COINS];
  logic [PW-1:0] yoff_d  [NUM_COINS];

  logic [9:0]    addr_q, addr_d;
  logic          insp_q, insp_d;
  logic [CW-1:0] hit_q, hit_d;
  logic [CW:0]   cnt_q, cnt_d;
  logic          pulse_q, pulse_d;
  logic          accept;

  // Lifecycle, shadow config and animation counters
  always_comb begin
    tick_d  = (hcount_in == 11'd0) && (vcount_in == 10'd0);
    div_d   = div_q;
    anim_d  = anim_q;
    sh_x_d  = sh_x_q;
    sh_y_d  = sh_y_q;
    sh_en_d = sh_en_q;
    x_d     = x_q;
    y_d     = y_q;
    state_d = state_q;
    pend_d  = pend_q;
    pop_d   = pop_q;
    yoff_d  = yoff_q;
    cnt_d   = cnt_q;

    accept  = collect_valid_in && (state_q[collect_idx_in] == S_SPIN) &&
              !pend_q[collect_idx_in];
    pulse_d = accept;

    if (cfg_valid_in) begin
      sh_x_d[cfg_idx_in]  = cfg_x_in;
      sh_y_d[cfg_idx_in]  = cfg_y_in;
      sh_en_d[cfg_idx_in] = cfg_en_in;
    end
    if (accept) pend_d[collect_idx_in] = 1'b1;

    if (tick_q) begin
      if (div_q == DW'(ANIM_DIV - 1)) begin
        div_d  = '0;
        anim_d = (anim_q == FW'(NUM_FRAMES - 1)) ? '0 : anim_q + FW'(1);
      end else begin
        div_d  = div_q + DW'(1);
      end

      cnt_d = '0;
      for (int unsigned i = 0; i < NUM_COINS; i++) begin
        x_d[i] = sh_x_q[i];
        y_d[i] = sh_y_q[i];
        case (state_q[i])
          S_OFF: begin
            if (sh_en_q[i]) state_d[i] = S_SPIN;
          end
          S_SPIN: begin
            // A disable outranks a pending collect; either exit drops pending,
            // including one accepted in this very cycle.
            if (!sh_en_q[i]) begin
              state_d[i] = S_OFF;
              pend_d[i]  = 1'b0;
            end else if (pend_q[i]) begin
              state_d[i] = S_POP;
              pend_d[i]  = 1'b0;
              pop_d[i]   = PW'(POP_FRAMES - 1);
              yoff_d[i]  = '0;
            end
          end
          S_POP: begin
            if (pop_q[i] == '0) begin
              state_d[i] = S_OFF;
              if (!(cfg_valid_in && (cfg_idx_in == CW'(i)))) sh_en_d[i] = 1'b0;
            end else begin
              pop_d[i]  = pop_q[i] - PW'(1);
              yoff_d[i] = yoff_q[i] + PW'(1);
            end
          end
          default: state_d[i] = S_OFF;
        endcase
        if (state_d[i] != S_OFF) cnt_d = cnt_d + (CW+1)'(1);
      end
    end
  end

  // Per-pixel hit test, lowest index wins
  logic [11:0]  hx, xl;
  logic [10:0]  vy, top;
  int unsigned  frm;
  logic         found;

  always_comb begin
    addr_d = '0;
    insp_d = 1'b0;
    hit_d  = '0;
    found  = 1'b0;
    hx     = {1'b0, hcount_in};
    vy     = {1'b0, vcount_in};
    xl     = '0;
    top    = '0;
    frm    = 0;
    for (int unsigned i = 0; i < NUM_COINS; i++) begin
      xl  = {1'b0, x_q[i]};
      // Rising coin is clamped at the top of the screen.
      top = (32'(yoff_q[i]) > 32'(y_q[i])) ? '0 : {1'b0, y_q[i] - 10'(yoff_q[i])};
      frm = (state_q[i] == S_POP) ? 0 : (32'(anim_q) + i) % NUM_FRAMES;
      if (!found && (state_q[i] != S_OFF) &&
          (hx >= xl) && (hx < xl + 12'(SPR_W)) &&
          (vy >= top) && (vy < top + 11'(SPR_W))) begin
        found  = 1'b1;
        insp_d = 1'b1;
        hit_d  = CW'(i);
        addr_d = 10'(frm * SPR_W * SPR_W + 32'(vy - top) * SPR_W + 32'(hx - xl));
      end
    end
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tick_q  <= 1'b0;
      div_q   <= '0;
      anim_q  <= '0;
      sh_x_q  <= '{default: '0};
      sh_y_q  <= '{default: '0};
      sh_en_q <= '{default: 1'b0};
      x_q     <= '{default: '0};
      y_q     <= '{default: '0};
      state_q <= '{default: S_OFF};
      pend_q  <= '{default: 1'b0};
      pop_q   <= '{default: '0};
      yoff_q  <= '{default: '0};
      addr_q  <= '0;
      insp_q  <= 1'b0;
      hit_q   <= '0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      tick_q  <= tick_d;
      div_q   <= div_d;
      anim_q  <= anim_d;
      sh_x_q  <= sh_x_d;
      sh_y_q  <= sh_y_d;
      sh_en_q <= sh_en_d;
      x_q     <= x_d;
      y_q     <= y_d;
      state_q <= state_d;
      pend_q  <= pend_d;
      pop_q   <= pop_d;
      yoff_q  <= yoff_d;
      addr_q  <= addr_d;
      insp_q  <= insp_d;
      hit_q   <= hit_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign image_addr_out      = addr_q;
  assign in_sprite_out       = insp_q;
  assign hit_idx_out         = hit_q;
  assign active_count_out    = cnt_q;
  assign collected_pulse_out = pulse_q;

endmodule

// File: tb/tb_coin_sprite_scheduler.sv
// Directed bench for coin_sprite_scheduler: inputs driven and outputs
// sampled on the falling clock edge.
module tb_coin_sprite_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        cfg_valid;
  logic [2:0]  cfg_idx;
  logic [10:0] cfg_x;
  logic [9:0]  cfg_y;
  logic        cfg_en;
  logic        col_valid;
  logic [2:0]  col_idx;
  logic [9:0]  addr;
  logic        in_sprite;
  logic [2:0]  hit_idx;
  logic [3:0]  active_count;
  logic        pulse;

  int n_checks = 0;
  int n_fail   = 0;
  int ntick    = 0;

  always #5 clk = ~clk;

  coin_sprite_scheduler dut (
    .pixel_clk_in        (clk),
    .rst_n_in            (rst_n),
    .hcount_in           (hcount),
    .vcount_in           (vcount),
    .cfg_valid_in        (cfg_valid),
    .cfg_idx_in          (cfg_idx),
    .cfg_x_in            (cfg_x),
    .cfg_y_in            (cfg_y),
    .cfg_en_in           (cfg_en),
    .collect_valid_in    (col_valid),
    .collect_idx_in      (col_idx),
    .image_addr_out      (addr),
    .in_sprite_out       (in_sprite),
    .hit_idx_out         (hit_idx),
    .active_count_out    (active_count),
    .collected_pulse_out (pulse)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Parks the beam off all coins.
  task automatic park();
    hcount = 11'd2000;
    vcount = 10'd1000;
  endtask

  task automatic do_tick();
    hcount = '0;
    vcount = '0;
    @(negedge clk);
    park();
    @(negedge clk);
    @(negedge clk);
    ntick++;
  endtask

  task automatic px(input int h, input int v);
    hcount = 11'(h);
    vcount = 10'(v);
    @(negedge clk);
  endtask

  task automatic cfg(input int idx, input int x, input int y, input logic en);
    cfg_valid = 1'b1;
    cfg_idx   = 3'(idx);
    cfg_x     = 11'(x);
    cfg_y     = 10'(y);
    cfg_en    = en;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic collect(input int idx, input logic exp_pulse, input string tag);
    col_valid = 1'b1;
    col_idx   = 3'(idx);
    @(negedge clk);
    col_valid = 1'b0;
    check(tag, 32'(pulse), 32'(exp_pulse));
  endtask

  initial begin
    rst_n = 1'b0;
    park();
    cfg_valid = 1'b0; cfg_idx = '0; cfg_x = '0; cfg_y = '0; cfg_en = 1'b0;
    col_valid = 1'b0; col_idx = '0;
    repeat (3) @(negedge clk);
    check("rst_addr",   32'(addr), 0);
    check("rst_insp",   32'(in_sprite), 0);
    check("rst_hit",    32'(hit_idx), 0);
    check("rst_count",  32'(active_count), 0);
    check("rst_pulse",  32'(pulse), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Config lands in shadow only; visible after the next frame tick
    cfg(2, 100, 50, 1'b1);
    px(103, 55);
    check("pre_tick_insp",  32'(in_sprite), 0);
    check("pre_tick_count", 32'(active_count), 0);
    do_tick();
    check("tick1_count", 32'(active_count), 1);
    px(103, 55);
    check("c2_insp", 32'(in_sprite), 1);
    check("c2_hit",  32'(hit_idx), 2);
    check("c2_addr", 32'(addr), 595);

    // Sprite box edges
    px(115, 65);  check("c2_corner_addr", 32'(addr), 767);
    check("c2_corner_insp", 32'(in_sprite), 1);
    px(116, 55);  check("c2_right_out", 32'(in_sprite), 0);
    check("c2_right_addr", 32'(addr), 0);
    px(99, 55);   check("c2_left_out",   32'(in_sprite), 0);
    px(103, 66);  check("c2_below_out",  32'(in_sprite), 0);
    px(103, 49);  check("c2_above_out",  32'(in_sprite), 0);

    // Animation: anim steps every 8 ticks and wraps after 32
    for (int k = 2; k <= 32; k++) begin
      do_tick();
      px(103, 55);
      check("anim_addr", 32'(addr), 32'((((ntick / 8) + 2) % 4) * 256 + 83));
    end
    px(103, 55);
    check("anim_wrap_addr", 32'(addr), 595);

    // Overlap: lower index wins
    cfg(1, 200, 200, 1'b1);
    cfg(4, 200, 200, 1'b1);
    do_tick();                                   // ntick 33, anim 0
    check("ovl_count", 32'(active_count), 3);
    px(205, 203);
    check("ovl_hit",  32'(hit_idx), 1);
    check("ovl_addr", 32'(addr), 309);
    cfg(1, 200, 200, 1'b0);
    do_tick();                                   // ntick 34
    check("ovl_off_count", 32'(active_count), 2);
    px(205, 203);
    check("ovl_off_hit",  32'(hit_idx), 4);
    check("ovl_off_addr", 32'(addr), 53);
    check("ovl_off_insp", 32'(in_sprite), 1);

    // Collect on an OFF coin is ignored
    collect(1, 1'b0, "off_collect_pulse");

    // Coin 3: last shadow write wins
    cfg(3, 900, 100, 1'b1);
    cfg(3, 300, 100, 1'b1);
    do_tick();                                   // ntick 35
    check("c3_count", 32'(active_count), 3);
    px(902, 104); check("c3_stale_insp", 32'(in_sprite), 0);
    px(302, 104);
    check("c3_spin_hit",  32'(hit_idx), 3);
    check("c3_spin_addr", 32'(addr), 834);
    px(205, 203); check("c1_still_off", 32'(hit_idx), 4);

    collect(3, 1'b1, "c3_collect_pulse");
    collect(3, 1'b0, "c3_second_collect");
    check("pulse_clear", 32'(pulse), 0);
    do_tick();                                   // ntick 36 -> POP, y_off 0
    check("pop_count", 32'(active_count), 3);
    px(302, 104);
    check("pop0_addr", 32'(addr), 66);
    check("pop0_hit",  32'(hit_idx), 3);
    for (int k = 1; k <= 15; k++) begin
      do_tick();
      px(302, 100 - k);
      check("pop_top_addr", 32'(addr), 2);
      check("pop_top_insp", 32'(in_sprite), 1);
      px(302, 99 - k);
      check("pop_above_insp", 32'(in_sprite), 0);
    end
    px(302, 100); check("pop15_bottom_addr", 32'(addr), 242);
    px(302, 101); check("pop15_below_insp", 32'(in_sprite), 0);
    do_tick();                                   // pop_ctr was 0 -> OFF
    check("pop_done_count", 32'(active_count), 2);
    px(302, 90);  check("pop_done_insp", 32'(in_sprite), 0);
    do_tick();
    check("pop_stays_off", 32'(active_count), 2);

    // Same-cycle disable and collect: pulse, then straight to OFF
    cfg_valid = 1'b1; cfg_idx = 3'd2; cfg_x = 11'd100; cfg_y = 10'd50; cfg_en = 1'b0;
    col_valid = 1'b1; col_idx = 3'd2;
    @(negedge clk);
    cfg_valid = 1'b0; col_valid = 1'b0;
    check("dis_collect_pulse", 32'(pulse), 1);
    do_tick();                                   // ntick 54, anim 2
    check("dis_count", 32'(active_count), 1);
    px(103, 55);  check("dis_insp", 32'(in_sprite), 0);
    px(103, 44);  check("dis_not_pop", 32'(in_sprite), 0);

    // Asynchronous reset mid-line
    px(205, 203);
    check("pre_rst_insp", 32'(in_sprite), 1);
    check("pre_rst_addr", 32'(addr), 565);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_insp",  32'(in_sprite), 0);
    check("async_rst_addr",  32'(addr), 0);
    check("async_rst_hit",   32'(hit_idx), 0);
    check("async_rst_count", 32'(active_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_tick();
    check("post_rst_count", 32'(active_count), 0);
    px(205, 203); check("post_rst_insp", 32'(in_sprite), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
